// File: rtl/pipe_cla_pkg.sv
// -----------------------------------------------------------------------------
// pipe_cla_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   DEF_WIDTH   : default operand/result width
//   DEF_SEG     : default bits resolved per pipeline stage
//   calc_nstage : pipeline depth for a given width/segment size
// -----------------------------------------------------------------------------
package pipe_cla_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    function automatic int calc_nstage(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// -----------------------------------------------------------------------------
// cla_segment
// Purely combinational SEG-bit carry-lookahead adder slice.
//   a, b : segment operands
//   cin  : carry into bit 0 of the segment
//   s    : segment sum
//   cout : carry out of the segment MSB
// -----------------------------------------------------------------------------
module cla_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is built as a flat sum of products from the generate and
    // propagate terms (no ripple chain): c[i+1] = g[i] | p[i]g[i-1] | ...
    // | p[i..0]cin.
    always_comb begin
        logic w_ci;
        logic w_t;
        w_ci   = 1'b0;
        w_t    = 1'b0;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            w_ci = cin;
            for (int m = 0; m <= i; m++) w_ci = w_ci & w_p[m];
            for (int j = 0; j <= i; j++) begin
                w_t = w_g[j];
                for (int m = j + 1; m <= i; m++) w_t = w_t & w_p[m];
                w_ci = w_ci | w_t;
            end
            w_c[i+1] = w_ci;
        end
    end

    assign s    = w_p ^ w_c[SEG-1:0];
    assign cout = w_c[SEG];

endmodule

// File: rtl/pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// pipe_cla_adder
// Pipelined add/subtract unit. Each of NSTAGE = WIDTH/SEG stages resolves one
// SEG-bit segment with a carry-lookahead slice and hands its carry to the
// next stage. Valid/ready handshake on both sides; one global advance enable.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = !out_valid || out_ready)
//   A, B, Cin, sub       : operands; sub=1 gives A-B (Cin ignored)
//   out_valid / out_ready: result handshake
//   S, Cout, ovf         : sum/difference, raw MSB carry, signed overflow
// -----------------------------------------------------------------------------
module pipe_cla_adder
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int NSTAGE = calc_nstage(WIDTH, SEG);

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipe_cla_adder: WIDTH must be a positive multiple of SEG");
    end

    logic w_adv;

    // Whole pipe moves as one; a stalled output freezes every stage.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int LO = k * SEG;       // bits already resolved upstream
        localparam int HI = WIDTH - LO;    // operand bits still to resolve

        logic              w_v;
        logic              w_ci;
        logic [HI-1:0]     w_a;
        logic [HI-1:0]     w_bx;
        logic [SEG-1:0]    w_seg_s;
        logic              w_seg_c;
        logic [LO+SEG-1:0] w_s;
        logic              r_v;
        logic              r_c;
        logic [LO+SEG-1:0] r_s;

        if (k == 0) begin : g_src
            // Subtract folds into the add as A + ~B + 1.
            assign w_v  = in_valid;
            assign w_ci = sub ? 1'b1 : Cin;
            assign w_a  = A;
            assign w_bx = sub ? ~B : B;
            assign w_s  = w_seg_s;
        end else begin : g_src
            assign w_v  = g_stage[k-1].r_v;
            assign w_ci = g_stage[k-1].r_c;
            assign w_a  = g_stage[k-1].g_fwd.r_a;
            assign w_bx = g_stage[k-1].g_fwd.r_bx;
            assign w_s  = {w_seg_s, g_stage[k-1].r_s};
        end

        cla_segment #(.SEG(SEG)) u_seg (
            .a    (w_a[SEG-1:0]),
            .b    (w_bx[SEG-1:0]),
            .cin  (w_ci),
            .s    (w_seg_s),
            .cout (w_seg_c)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v;
                r_c <= w_seg_c;
                r_s <= w_s;
            end
        end

        if (k < NSTAGE - 1) begin : g_fwd
            // Only the not-yet-resolved upper operand bits travel onward;
            // they are qualified by r_v so they need no reset.
            logic [HI-SEG-1:0] r_a;
            logic [HI-SEG-1:0] r_bx;

            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a  <= w_a[HI-1:SEG];
                    r_bx <= w_bx[HI-1:SEG];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Operand MSBs are only visible here, so overflow is resolved in
            // the final stage and registered with the sum.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= (w_a[HI-1] == w_bx[HI-1]) &&
                             (w_seg_s[SEG-1] != w_a[HI-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[NSTAGE-1].r_v;
    assign S         = g_stage[NSTAGE-1].r_s;
    assign Cout      = g_stage[NSTAGE-1].r_c;
    assign ovf       = g_stage[NSTAGE-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_cla_adder
// Self-checking bench: arithmetic reference model with an in-order queue,
// directed literal cases, stall/reset scenarios and a randomized stream.
// -----------------------------------------------------------------------------
module tb_pipe_cla_adder;

    localparam int NSTAGE = 4;
    localparam int NRAND  = 10000;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        Cout;
    logic        ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc    = 0;
    exp_t q[$];
    logic prev_stall = 1'b0;
    logic prev_rst   = 1'b0;
    exp_t prev_out   = '0;

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .ovf       (ovf)
    );

    // Reference: plain integer arithmetic; overflow = true signed result out
    // of 32-bit range, Cout for subtract = "no borrow" (A >= B unsigned).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        exp_t        e;
        longint      sr;
        logic [32:0] u;
        if (sb) begin
            e.s = a - b;
            e.c = (a >= b);
            sr  = longint'($signed(a)) - longint'($signed(b));
        end else begin
            u   = {1'b0, a} + {1'b0, b} + 33'(ci);
            e.s = u[31:0];
            e.c = u[32];
            sr  = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        end
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic put(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb);
        @(posedge clk);
        #1;
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = ci;
        sub      = sb;
    endtask

    // Single isolated transaction: checks exact latency and literal result.
    task automatic one(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb,
                       input logic [31:0] es, input logic ec, input logic eo);
        put(1'b1, a, b, ci, sb);
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= NSTAGE; i++) begin
            @(negedge clk);
            if (i < NSTAGE) begin
                chk({nm, "_early"}, 64'(out_valid), 64'd0);
            end else begin
                chk({nm, "_valid"}, 64'(out_valid), 64'd1);
                chk({nm, "_result"}, 64'({S, Cout, ovf}), 64'({es, ec, eo}));
            end
        end
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t cur;
        logic rdy;
        cur = {S, Cout, ovf};
        if (prev_rst) begin
            chk("reset_valid", 64'(out_valid), 64'd0);
            chk("reset_outputs", 64'(cur), 64'd0);
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", 64'(out_valid), 64'd1);
                chk("stall_data_hold", 64'(cur), 64'(prev_out));
            end
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_result", 64'(out_valid), 64'd0);
                else               chk("result", 64'(cur), 64'(q[0]));
            end
        end
        rdy = !out_valid || out_ready;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && rdy) begin
            q.push_back(model(A, B, Cin, sub));
            n_acc++;
        end
        if (!rst_n) q.delete();
        prev_stall = out_valid && !out_ready && rst_n;
        prev_out   = cur;
        prev_rst   = !rst_n;
    end

    initial begin
        exp_t        held;
        logic        got;
        int          cnt;
        int          base;
        logic [31:0] b2b_s[3];
        logic        b2b_c[3];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'({S, Cout, ovf}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        one("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        one("sub_neg",  32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        one("sub_cin",  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        one("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Back-to-back: results on three consecutive cycles starting cycle 4.
        b2b_s = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h9999_9999};
        b2b_c = '{1'b1, 1'b1, 1'b0};
        put(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
        put(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        put(1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_cycle3_idle", 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_result", 64'({S, Cout}), 64'({b2b_s[i], b2b_c[i]}));
        end
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Backpressure: hold out_ready low for 3 cycles on a valid result.
        out_ready = 1'b0;
        put(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        put(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        put(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        put(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("stall_arrive", 64'(got), 64'd1);
        held = {S, Cout, ovf};
        chk("stall_first", 64'(held), 64'({32'hFFFF_FFFE, 1'b0, 1'b0}));
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0);
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_stable", 64'({S, Cout, ovf}), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("stall_release_count", 64'(cnt), 64'd3);

        // Reset with three transactions in flight.
        put(1'b1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        put(1'b1, 32'h0000_3333, 32'h0000_4444, 1'b1, 1'b0);
        put(1'b1, 32'h0000_5555, 32'h0000_0001, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_outputs", 64'({S, Cout, ovf}), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("midrst_no_stale", 64'(cnt), 64'd0);

        // Random mixed add/sub stream with random handshakes.
        base = n_acc;
        for (int cyc = 0; cyc < 60000 && (n_acc - base) < NRAND; cyc++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 8);
            A         = rnd();
            B         = rnd();
            Cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
        end
        chk("random_accepted", 64'(n_acc - base >= NRAND), 64'd1);

        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 8, bits resolved per pipeline stage; WIDTH SHALL be an integer multiple of SEG (elaboration error otherwise).
REQ-003 SHALL derive NSTAGE = WIDTH/SEG as the pipeline depth.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, reset (one clock; reset is synchronous and active-low).
REQ-006 SHALL have port in_valid, input, 1, operands present this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have port A, input, WIDTH, operand A.
REQ-009 SHALL have port B, input, WIDTH, operand B.
REQ-010 SHALL have port Cin, input, 1, carry-in (add mode only).
REQ-011 SHALL have port sub, input, 1, 0 = A+B+Cin, 1 = A-B (Cin ignored).
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-014 SHALL have port S, output, WIDTH, sum/difference.
REQ-015 SHALL have port Cout, output, 1, raw carry out of MSB.
REQ-016 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-017 SHALL compute {Cout,S} = A + B' + c0, where B' = sub ? ~B : B and c0 = sub ? 1 : Cin.
REQ-018 SHALL compute ovf = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]).
REQ-019 Stage k (0..NSTAGE-1) SHALL resolve bits [k*SEG +: SEG] with a SEG-bit carry-lookahead, taking the carry registered by stage k-1 (c0 for stage 0).
REQ-020 Operand segments for stage k SHALL be delayed by k register stages; resolved lower segments SHALL be carried forward alongside, so each in-flight transaction is kept intact.
REQ-021 Global advance condition adv = !out_valid || out_ready; all pipeline registers (data and per-stage valid) SHALL update only when adv = 1.
REQ-022 in_ready SHALL equal adv (combinational); a transfer occurs when in_valid && in_ready.
REQ-023 Latency SHALL be exactly NSTAGE cycles from accepted input to out_valid, with no stalls.
REQ-024 Throughput SHALL be one transaction per cycle while out_ready stays 1.
REQ-025 When adv = 1 and in_valid = 0, a bubble (valid = 0) SHALL enter stage 0; bubbles are not collapsed.
REQ-026 While out_valid && !out_ready, S, Cout and ovf SHALL hold stable and no input SHALL be accepted.
REQ-027 S, Cout and ovf SHALL be registered outputs; their values when out_valid = 0 are don't-care except after reset.
REQ-028 sub and Cin SHALL be sampled with the operands and travel with the transaction; mixed add/sub streams SHALL be correct per transaction.

Reset
REQ-029 When rst_n = 0 at a rising clk edge, all stage valids, out_valid, S, Cout and ovf SHALL be cleared to 0, overriding adv.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; in_ready SHALL read 1 in the first cycle after reset release.

Structure
REQ-031 A shared package pipe_cla_pkg SHALL hold the default constants (WIDTH 32, SEG 8) and the NSTAGE derivation function.
REQ-032 One sub-module cla_segment (purely combinational, parameter SEG; ports a, b, cin, s, cout) SHALL be instantiated once per stage via generate.

Verification (WIDTH=32, SEG=8, NSTAGE=4)
REQ-033 A=FFFFFFFF, B=00000001, Cin=0, sub=0 -> 4 cycles later S=00000000, Cout=1, ovf=0.
REQ-034 A=7FFFFFFF, B=00000001, sub=0 -> S=80000000, Cout=0, ovf=1; A=00000000, B=00000001, sub=1 -> S=FFFFFFFF, Cout=0, ovf=0.
REQ-035 Back-to-back AAAAAAAA+55555555 Cin=1, FFFFFFFF+FFFFFFFF Cin=1, 12345678+87654321 Cin=0 on consecutive cycles, out_ready=1 -> results 00000000/C1, FFFFFFFF/C1, 99999999/C0 on three consecutive cycles starting cycle 4.
REQ-036 out_ready held 0 for 3 cycles while a result is valid -> in_ready=0, S/Cout/ovf stable; after release all queued results emerge in order, none lost or duplicated.
REQ-037 rst_n pulsed low for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle, no stale result ever appears, S=0, Cout=0, ovf=0.
REQ-038 Random add/sub streams with random in_valid/out_ready for 10000 transactions -> every result matches the REQ-017/REQ-018 reference model, in order.
